// File: rtl/dram_port_arbiter_pkg.sv
// rtl/dram_port_arbiter_pkg.sv - shared encodings for the DRAM port arbiter
//
// Purpose: DDR command codes, requester identifiers and the lock-state
//          encoding used by the arbiter and its owner FIFOs.
// Ports:   none (package)
package dram_port_arbiter_pkg;

   localparam logic [2:0] DDR_CMD_WRITE = 3'b000;
   localparam logic [2:0] DDR_CMD_READ  = 3'b001;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_e;

   // LOCK_HELD means a command is on the DRAM port and has not been accepted
   typedef enum logic {
      LOCK_IDLE = 1'b0,
      LOCK_HELD = 1'b1
   } lockState_e;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// rtl/dram_port_arbiter_if.sv - memory-controller side port of the DRAM arbiter
//
// Purpose: bundles the command, write-data and read-data channels of the
//          single DRAM controller port.
// Ports:   master modport = arbiter side (drives command and write data),
//          slave modport  = memory controller side.
interface dram_port_arbiter_if #(
   parameter int DDRAWidth = 28,
   parameter int DDRCWidth = 3,
   parameter int DDRDWidth = 512,
   parameter int DDRMWidth = 64
);

   logic [DDRAWidth-1:0] DRAMAddress;
   logic [DDRCWidth-1:0] DRAMCommand;
   logic                 DRAMCommandValid;
   logic                 DRAMCommandReady;
   logic [DDRDWidth-1:0] DRAMWriteData;
   logic [DDRMWidth-1:0] DRAMWriteMask;
   logic                 DRAMWriteDataValid;
   logic                 DRAMWriteDataReady;
   logic [DDRDWidth-1:0] DRAMReadData;
   logic                 DRAMReadDataValid;

   modport master (
      output DRAMAddress, DRAMCommand, DRAMCommandValid,
      input  DRAMCommandReady,
      output DRAMWriteData, DRAMWriteMask, DRAMWriteDataValid,
      input  DRAMWriteDataReady,
      input  DRAMReadData, DRAMReadDataValid
   );

   modport slave (
      input  DRAMAddress, DRAMCommand, DRAMCommandValid,
      output DRAMCommandReady,
      input  DRAMWriteData, DRAMWriteMask, DRAMWriteDataValid,
      output DRAMWriteDataReady,
      output DRAMReadData, DRAMReadDataValid
   );

endinterface

// File: rtl/dram_port_arbiter_owner_fifo.sv
// rtl/dram_port_arbiter_owner_fifo.sv - owner FIFO tracking which requester owns each outstanding transfer
//
// Purpose: small synchronous FIFO; one entry per outstanding command.
// Ports:   Clock, Reset (async active-low), Push/InBit write side,
//          Pop/OutBit read side (OutBit is the current head), Empty, Full.
module dram_port_arbiter_owner_fifo #(
   parameter int Width = 1,
   parameter int Depth = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Push,
   input  logic             Pop,
   input  logic [Width-1:0] InBit,
   output logic [Width-1:0] OutBit,
   output logic             Empty,
   output logic             Full
);

   localparam int AW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [AW:0]      count;
   logic             doPush;
   logic             doPop;

   assign doPush = Push & ~Full;
   assign doPop  = Pop & ~Empty;
   assign Empty  = (count == '0);
   assign Full   = (count == (AW+1)'(Depth));
   assign OutBit = mem[rdPtr];

   // Depth is a power of two, so pointers wrap naturally
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (doPush) mem[wrPtr] <= InBit;
   end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin sharing of one DRAM controller port between two requesters
//
// Purpose: grants commands round-robin between requester 0 (ORAM backend) and
//          requester 1 (secondary client), holds a stalled grant until the
//          controller accepts it, and routes write data / read data to the
//          requester that issued each command via two owner FIFOs.
// Ports:   Clock, Reset (async active-low)
//          R0*/R1* command (Addr, Cmd, Valid, Ready), write (Data, Mask,
//          Valid, Ready) and read (Data, Valid) channels per requester
//          dram : memory-controller port (master modport)
//          ProtocolError : sticky, set by read data with nothing outstanding
module dram_port_arbiter
   import dram_port_arbiter_pkg::*;
#(
   parameter int DDRAWidth = 28,
   parameter int DDRCWidth = 3,
   parameter int DDRDWidth = 512,
   parameter int DDRMWidth = 64,
   parameter int OwnDepth  = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,

   input  logic [DDRAWidth-1:0] R0CmdAddr,
   input  logic [DDRCWidth-1:0] R0Cmd,
   input  logic                 R0CmdValid,
   output logic                 R0CmdReady,
   input  logic [DDRDWidth-1:0] R0WrData,
   input  logic [DDRMWidth-1:0] R0WrMask,
   input  logic                 R0WrValid,
   output logic                 R0WrReady,
   output logic [DDRDWidth-1:0] R0RdData,
   output logic                 R0RdValid,

   input  logic [DDRAWidth-1:0] R1CmdAddr,
   input  logic [DDRCWidth-1:0] R1Cmd,
   input  logic                 R1CmdValid,
   output logic                 R1CmdReady,
   input  logic [DDRDWidth-1:0] R1WrData,
   input  logic [DDRMWidth-1:0] R1WrMask,
   input  logic                 R1WrValid,
   output logic                 R1WrReady,
   output logic [DDRDWidth-1:0] R1RdData,
   output logic                 R1RdValid,

   dram_port_arbiter_if.master  dram,

   output logic                 ProtocolError
);

   logic       r0IsRd, r0IsWr, r1IsRd, r1IsWr;
   logic       elig0, elig1;
   logic       rdFull, rdEmpty, rdHead;
   logic       wrFull, wrEmpty, wrHead;
   logic       rdPush, rdPop, wrPush, wrPop;
   logic       wrHeadValid;
   logic       cmdValid, accept;
   lockState_e stateQ, stateD;
   req_e       selQ, selD, sel, pick, lastQ;

   assign r0IsRd = (R0Cmd == DDRCWidth'(DDR_CMD_READ));
   assign r0IsWr = (R0Cmd == DDRCWidth'(DDR_CMD_WRITE));
   assign r1IsRd = (R1Cmd == DDRCWidth'(DDR_CMD_READ));
   assign r1IsWr = (R1Cmd == DDRCWidth'(DDR_CMD_WRITE));

   // A command is only offered when its owner FIFO has room for the push
   assign elig0 = R0CmdValid & ((r0IsRd & ~rdFull) | (r0IsWr & ~wrFull));
   assign elig1 = R1CmdValid & ((r1IsRd & ~rdFull) | (r1IsWr & ~wrFull));

   // Round-robin pick for the unlocked case: a tie goes to the one that did not win last
   always_comb begin
      pick = REQ0;
      if (elig0 && elig1) begin
         pick = (lastQ == REQ0) ? REQ1 : REQ0;
      end else if (elig1) begin
         pick = REQ1;
      end
   end

   always_comb begin
      stateD   = stateQ;
      selD     = selQ;
      sel      = selQ;
      cmdValid = 1'b0;
      case (stateQ)
         LOCK_IDLE: begin
            sel      = pick;
            cmdValid = Reset & (elig0 | elig1);
            if (cmdValid && !dram.DRAMCommandReady) begin
               stateD = LOCK_HELD;
               selD   = pick;
            end
         end
         LOCK_HELD: begin
            // The held requester keeps the port; a newcomer cannot preempt.
            // Release on acceptance, or if the holder withdraws its request.
            sel      = selQ;
            cmdValid = Reset & ((selQ == REQ0) ? elig0 : elig1);
            if (!cmdValid || dram.DRAMCommandReady) begin
               stateD = LOCK_IDLE;
            end
         end
         default: stateD = LOCK_IDLE;
      endcase
   end

   assign accept = cmdValid & dram.DRAMCommandReady;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         stateQ        <= LOCK_IDLE;
         selQ          <= REQ0;
         lastQ         <= REQ1;
         ProtocolError <= 1'b0;
      end else begin
         stateQ <= stateD;
         selQ   <= selD;
         if (accept) lastQ <= sel;
         if (dram.DRAMReadDataValid && rdEmpty) ProtocolError <= 1'b1;
      end
   end

   // Command channel
   assign dram.DRAMAddress      = (sel == REQ1) ? R1CmdAddr : R0CmdAddr;
   assign dram.DRAMCommand      = (sel == REQ1) ? R1Cmd : R0Cmd;
   assign dram.DRAMCommandValid = cmdValid;
   assign R0CmdReady            = accept & (sel == REQ0);
   assign R1CmdReady            = accept & (sel == REQ1);

   assign rdPush = accept & ((sel == REQ1) ? r1IsRd : r0IsRd);
   assign wrPush = accept & ((sel == REQ1) ? r1IsWr : r0IsWr);

   // Write channel: only the owner at the FIFO head may move data, and never
   // through an empty FIFO, so data cannot overtake its own command
   assign wrHeadValid             = wrHead ? R1WrValid : R0WrValid;
   assign dram.DRAMWriteData      = wrHead ? R1WrData : R0WrData;
   assign dram.DRAMWriteMask      = wrHead ? R1WrMask : R0WrMask;
   assign dram.DRAMWriteDataValid = ~wrEmpty & wrHeadValid;
   assign R0WrReady               = ~wrEmpty & ~wrHead & dram.DRAMWriteDataReady;
   assign R1WrReady               = ~wrEmpty &  wrHead & dram.DRAMWriteDataReady;
   assign wrPop                   = dram.DRAMWriteDataValid & dram.DRAMWriteDataReady;

   // Read channel: no backpressure, bursts return in command order
   assign rdPop     = dram.DRAMReadDataValid & ~rdEmpty;
   assign R0RdValid = rdPop & ~rdHead;
   assign R1RdValid = rdPop &  rdHead;
   assign R0RdData  = dram.DRAMReadData;
   assign R1RdData  = dram.DRAMReadData;

   dram_port_arbiter_owner_fifo #(
      .Width (1),
      .Depth (OwnDepth)
   ) rdOwn (
      .Clock  (Clock),
      .Reset  (Reset),
      .Push   (rdPush),
      .Pop    (rdPop),
      .InBit  (sel == REQ1),
      .OutBit (rdHead),
      .Empty  (rdEmpty),
      .Full   (rdFull)
   );

   dram_port_arbiter_owner_fifo #(
      .Width (1),
      .Depth (OwnDepth)
   ) wrOwn (
      .Clock  (Clock),
      .Reset  (Reset),
      .Push   (wrPush),
      .Pop    (wrPop),
      .InBit  (sel == REQ1),
      .OutBit (wrHead),
      .Empty  (wrEmpty),
      .Full   (wrFull)
   );

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - directed self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;

   localparam int AW = 28;
   localparam int CW = 3;
   localparam int DW = 512;
   localparam int MW = 64;
   localparam logic [2:0] WR = 3'b000;
   localparam logic [2:0] RD = 3'b001;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [AW-1:0] R0CmdAddr, R1CmdAddr;
   logic [CW-1:0] R0Cmd, R1Cmd;
   logic          R0CmdValid, R1CmdValid, R0CmdReady, R1CmdReady;
   logic [DW-1:0] R0WrData, R1WrData, R0RdData, R1RdData;
   logic [MW-1:0] R0WrMask, R1WrMask;
   logic          R0WrValid, R1WrValid, R0WrReady, R1WrReady;
   logic          R0RdValid, R1RdValid;
   logic          ProtocolError;

   int checks = 0;
   int errors = 0;

   dram_port_arbiter_if #(.DDRAWidth(AW), .DDRCWidth(CW), .DDRDWidth(DW), .DDRMWidth(MW)) dram ();

   dram_port_arbiter #(
      .DDRAWidth(AW), .DDRCWidth(CW), .DDRDWidth(DW), .DDRMWidth(MW), .OwnDepth(16)
   ) dut (
      .Clock(Clock), .Reset(Reset),
      .R0CmdAddr(R0CmdAddr), .R0Cmd(R0Cmd), .R0CmdValid(R0CmdValid), .R0CmdReady(R0CmdReady),
      .R0WrData(R0WrData), .R0WrMask(R0WrMask), .R0WrValid(R0WrValid), .R0WrReady(R0WrReady),
      .R0RdData(R0RdData), .R0RdValid(R0RdValid),
      .R1CmdAddr(R1CmdAddr), .R1Cmd(R1Cmd), .R1CmdValid(R1CmdValid), .R1CmdReady(R1CmdReady),
      .R1WrData(R1WrData), .R1WrMask(R1WrMask), .R1WrValid(R1WrValid), .R1WrReady(R1WrReady),
      .R1RdData(R1RdData), .R1RdValid(R1RdValid),
      .dram(dram.master),
      .ProtocolError(ProtocolError)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset = 1'b0;
      R0CmdAddr = '0; R0Cmd = RD; R0CmdValid = 1'b1;
      R1CmdAddr = '0; R1Cmd = RD; R1CmdValid = 1'b0;
      R0WrData = '0; R0WrMask = '0; R0WrValid = 1'b0;
      R1WrData = '0; R1WrMask = '0; R1WrValid = 1'b0;
      dram.DRAMCommandReady = 1'b1;
      dram.DRAMWriteDataReady = 1'b1;
      dram.DRAMReadData = '0;
      dram.DRAMReadDataValid = 1'b0;

      // In reset: request offered, nothing may leave the block
      @(negedge Clock); #1;
      check("rst_cmdvalid", dram.DRAMCommandValid, 0);
      check("rst_r0cmdready", R0CmdReady, 0);
      check("rst_perr", ProtocolError, 0);

      // Alternating reads, R0 wins the first tie
      @(negedge Clock);
      Reset = 1'b1;
      R0CmdValid = 1'b1; R0Cmd = RD; R0CmdAddr = 28'h100;
      R1CmdValid = 1'b1; R1Cmd = RD; R1CmdAddr = 28'h200;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("alt_addr", dram.DRAMAddress, (i % 2 == 1) ? 64'h200 : 64'h100);
         check("alt_r0cmdready", R0CmdReady, (i % 2 == 0));
         check("alt_r1cmdready", R1CmdReady, (i % 2 == 1));
         @(negedge Clock);
      end
      R0CmdValid = 1'b0; R1CmdValid = 1'b0;
      dram.DRAMReadDataValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dram.DRAMReadData = DW'(i + 16);
         #1;
         check("alt_r0rdvalid", R0RdValid, (i % 2 == 0));
         check("alt_r1rdvalid", R1RdValid, (i % 2 == 1));
         check("alt_rddata", R0RdData[63:0], 64'(i + 16));
         @(negedge Clock);
      end
      dram.DRAMReadDataValid = 1'b0;

      // Lock: R1 stalled for 5 cycles, R0 arrives and must wait
      dram.DRAMCommandReady = 1'b0;
      R1CmdValid = 1'b1; R1Cmd = RD; R1CmdAddr = 28'h300;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            R0CmdValid = 1'b1; R0Cmd = RD; R0CmdAddr = 28'h400;
         end
         #1;
         check("lock_addr", dram.DRAMAddress, 64'h300);
         check("lock_cmdvalid", dram.DRAMCommandValid, 1);
         check("lock_r1cmdready", R1CmdReady, 0);
         @(negedge Clock);
      end
      dram.DRAMCommandReady = 1'b1;
      #1;
      check("lock_accept_r1", R1CmdReady, 1);
      check("lock_accept_r0", R0CmdReady, 0);
      check("lock_accept_addr", dram.DRAMAddress, 64'h300);
      @(negedge Clock);
      R1CmdValid = 1'b0;
      #1;
      check("lock_next_r0", R0CmdReady, 1);
      check("lock_next_addr", dram.DRAMAddress, 64'h400);
      @(negedge Clock);
      R0CmdValid = 1'b0;
      dram.DRAMReadDataValid = 1'b1;
      #1;
      check("lock_ret1_r1", R1RdValid, 1);
      check("lock_ret1_r0", R0RdValid, 0);
      @(negedge Clock); #1;
      check("lock_ret2_r0", R0RdValid, 1);
      check("lock_ret2_r1", R1RdValid, 0);
      @(negedge Clock);
      dram.DRAMReadDataValid = 1'b0;

      // Writes: R0 then R1 accepted; R1 data first, R0 data 3 cycles later
      R0CmdValid = 1'b1; R0Cmd = WR; R0CmdAddr = 28'h500;
      #1;
      check("wr_r0cmdready", R0CmdReady, 1);
      check("wr_cmd_code", dram.DRAMCommand, 0);
      @(negedge Clock);
      R0CmdValid = 1'b0;
      R1CmdValid = 1'b1; R1Cmd = WR; R1CmdAddr = 28'h600;
      R1WrValid = 1'b1; R1WrData = DW'(64'hB1); R1WrMask = 64'h0F;
      #1;
      check("wr_r1cmdready", R1CmdReady, 1);
      check("wr_r1wrready_early", R1WrReady, 0);
      check("wr_dvalid_early", dram.DRAMWriteDataValid, 0);
      @(negedge Clock);
      R1CmdValid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("wr_r1_wait", R1WrReady, 0);
         check("wr_dvalid_wait", dram.DRAMWriteDataValid, 0);
         @(negedge Clock);
      end
      R0WrValid = 1'b1; R0WrData = DW'(64'hA0); R0WrMask = 64'hF0;
      #1;
      check("wr_r0_dvalid", dram.DRAMWriteDataValid, 1);
      check("wr_r0_data", dram.DRAMWriteData[63:0], 64'hA0);
      check("wr_r0_mask", dram.DRAMWriteMask, 64'hF0);
      check("wr_r0wrready", R0WrReady, 1);
      check("wr_r1wrready_blk", R1WrReady, 0);
      @(negedge Clock);
      R0WrValid = 1'b0;
      #1;
      check("wr_r1_dvalid", dram.DRAMWriteDataValid, 1);
      check("wr_r1_data", dram.DRAMWriteData[63:0], 64'hB1);
      check("wr_r1_mask", dram.DRAMWriteMask, 64'h0F);
      check("wr_r1wrready", R1WrReady, 1);
      check("wr_r0wrready_off", R0WrReady, 0);
      @(negedge Clock); #1;
      check("wr_empty_r1ready", R1WrReady, 0);
      check("wr_empty_dvalid", dram.DRAMWriteDataValid, 0);
      @(negedge Clock);
      R1WrValid = 1'b0;

      // Read data with nothing outstanding
      dram.DRAMReadDataValid = 1'b1;
      #1;
      check("perr_r0rdvalid", R0RdValid, 0);
      check("perr_r1rdvalid", R1RdValid, 0);
      @(negedge Clock);
      dram.DRAMReadDataValid = 1'b0;
      #1;
      check("perr_set", ProtocolError, 1);

      // Fill RdOwn with 16 R0 reads; 17th blocked, R1 write still granted
      @(negedge Clock);
      R0CmdValid = 1'b1; R0Cmd = RD; R0CmdAddr = 28'h800;
      for (int i = 0; i < 16; i++) begin
         #1;
         check("full_fill", R0CmdReady, 1);
         @(negedge Clock);
      end
      #1;
      check("full_r0blocked", R0CmdReady, 0);
      check("full_cmdvalid", dram.DRAMCommandValid, 0);
      R1CmdValid = 1'b1; R1Cmd = WR; R1CmdAddr = 28'h900;
      #1;
      check("full_r1cmdready", R1CmdReady, 1);
      check("full_r0still", R0CmdReady, 0);
      check("full_r1addr", dram.DRAMAddress, 64'h900);
      @(negedge Clock);
      R0CmdValid = 1'b0; R1CmdValid = 1'b0;

      // Drain 13 of the 16 reads, leaving 3 outstanding
      dram.DRAMReadDataValid = 1'b1;
      for (int i = 0; i < 13; i++) begin
         #1;
         check("drain_r0rdvalid", R0RdValid, 1);
         @(negedge Clock);
      end
      dram.DRAMReadDataValid = 1'b0;
      #1;
      check("perr_sticky", ProtocolError, 1);

      // Locked grant, then asynchronous reset mid-cycle
      @(negedge Clock);
      dram.DRAMCommandReady = 1'b0;
      R0CmdValid = 1'b1; R0Cmd = RD; R0CmdAddr = 28'hA00;
      #1;
      check("rl_cmdvalid", dram.DRAMCommandValid, 1);
      @(negedge Clock);
      R1CmdValid = 1'b1; R1Cmd = RD; R1CmdAddr = 28'hB00;
      R1WrValid = 1'b1;
      dram.DRAMWriteDataReady = 1'b1;
      dram.DRAMReadDataValid = 1'b1;
      #1;
      check("rl_locked_addr", dram.DRAMAddress, 64'hA00);
      check("rl_pre_r0rdvalid", R0RdValid, 1);
      dram.DRAMCommandReady = 1'b1;
      #1;
      Reset = 1'b0;
      #1;
      check("rl_cmdvalid_rst", dram.DRAMCommandValid, 0);
      check("rl_r0cmdready_rst", R0CmdReady, 0);
      check("rl_r1cmdready_rst", R1CmdReady, 0);
      check("rl_r1wrready_rst", R1WrReady, 0);
      check("rl_dvalid_rst", dram.DRAMWriteDataValid, 0);
      check("rl_r0rdvalid_rst", R0RdValid, 0);
      check("rl_r1rdvalid_rst", R1RdValid, 0);
      check("rl_perr_rst", ProtocolError, 0);
      @(negedge Clock);
      dram.DRAMReadDataValid = 1'b0;
      Reset = 1'b1;
      R0CmdAddr = 28'hC00;
      #1;
      check("post_r0cmdready", R0CmdReady, 1);
      check("post_r1cmdready", R1CmdReady, 0);
      check("post_addr", dram.DRAMAddress, 64'hC00);
      check("post_wr_empty", dram.DRAMWriteDataValid, 0);
      @(negedge Clock);
      R0CmdValid = 1'b0; R1CmdValid = 1'b0; R1WrValid = 1'b0;
      dram.DRAMReadDataValid = 1'b1;
      #1;
      check("post_ret_r0", R0RdValid, 1);
      @(negedge Clock); #1;
      check("post_rd_empty", R0RdValid, 0);
      @(negedge Clock);
      dram.DRAMReadDataValid = 1'b0;
      #1;
      check("post_perr", ProtocolError, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
